// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the scratch word memory
package mem_pkg;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int DW = 16;
    typedef enum logic {SERVE, CLEAR} mc_state_t;
    typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] hi, sel;
    // Favour requesters at or above the pointer, otherwise wrap to the lowest one
    always_comb begin
        hi = '0;
        for (int i = 0; i < NREQ; i++) hi[i] = req[i] && (PW'(i) >= ptr_q);
        sel = (|hi) ? hi : req;
        gnt = en ? (sel & (~sel + NREQ'(1))) : '0;
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
    // Pointer moves just past the winner; idle cycles leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/word_mem_ctrl.sv
// word_mem_ctrl: shared 16x16 scratch memory with round-robin access and a clear sweep
module word_mem_ctrl
    import mem_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    input  logic               clr_start,
    output logic               busy
);
    mc_state_t state_q, state_d;
    logic busy_q, busy_d;
    logic [AW-1:0] cnt_q, cnt_d;
    word_t mem_q [DEPTH];
    word_t rdata_q, rdata_d, acc_wdata;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [AW-1:0] acc_addr;
    logic acc_we, en;

    // A clear command outranks every request, and reset blocks grants immediately
    assign en = rst_n && (state_q == SERVE) && !clr_start;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (en),
        .gnt   (gnt)
    );

    // Route the granted requester's address, data and direction to the memory
    always_comb begin
        acc_addr = addr[AW-1:0];
        acc_wdata = wdata[DW-1:0];
        acc_we = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                acc_addr = addr[k*AW +: AW];
                acc_wdata = wdata[k*DW +: DW];
                acc_we = we[k];
            end
        end
        rvalid_d = gnt & ~we;
        rdata_d = (|rvalid_d) ? mem_q[acc_addr] : rdata_q;
    end

    // Clear sequencer: one word per cycle, returning to service after the last word
    always_comb begin
        state_d = state_q;
        busy_d = busy_q;
        cnt_d = cnt_q;
        if (state_q == SERVE) begin
            if (clr_start) begin
                state_d = CLEAR;
                busy_d = 1'b1;
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = SERVE;
                busy_d = 1'b0;
            end
        end
    end

    // FSM state, sweep counter and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SERVE;
            busy_q <= 1'b0;
            cnt_q <= '0;
            rvalid_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q <= busy_d;
            cnt_q <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array: the sweep zeroes one word per cycle, otherwise the granted write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (acc_we) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata = rdata_q;
    assign busy = busy_q;
endmodule
